// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one conditional add and right shift
// per clock into a 2*WIDTH product register seeded with the multiplier.
module shift_add_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mcand_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [PW-1:0]    product_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    stepped;
  logic             accept;

  // One add/shift step; the carry out of the WIDTH+1 bit add lands in the MSB.
  always_comb begin
    upper   = product[PW-1:WIDTH];
    lower   = product[WIDTH-1:0];
    addend  = lower[0] ? mcand : '0;
    sum     = {1'b0, upper} + {1'b0, addend};
    stepped = {sum, lower[WIDTH-1:1]};
  end

  assign accept = (state != RUN) && start;

  // Next-state and next-register values.
  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    count_nxt   = count;
    product_nxt = product;
    busy_nxt    = busy;
    done_nxt    = done;

    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt   = RUN;
          product_nxt = {{WIDTH{1'b0}}, multiplier};
          mcand_nxt   = multiplicand;
          count_nxt   = '0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
        end
      end
      RUN: begin
        product_nxt = stepped;
        count_nxt   = count + CW'(1);
        if (count == LAST_STEP) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      count   <= count_nxt;
      product <= product_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult at WIDTH=32 and WIDTH=8.
module tb_shift_add_mult;

  logic        clk;
  logic        reset;
  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [63:0] p32;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  int n_cmp;
  int n_bad;

  shift_add_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(p32)
  );

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge, then scramble the operand inputs to prove they are don't-care.
  task automatic start_op32(input logic [31:0] a, input logic [31:0] b);
    a32 = a; b32 = b; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
  endtask

  task automatic wait_done32(input string tag, input logic [63:0] exp);
    int lat;
    lat = 0;
    while (!done32 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd32);
    check({tag, "_prod"}, p32, exp);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int lat;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'h5A; b8 = 8'hC3;
    check({tag, "_busy"}, 64'(busy8), 64'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_prod"}, 64'(p8), 64'(exp));
    check({tag, "_busy_low"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int first_done;
    int second_done;
    int done_cnt;
    logic [63:0] prod_a;
    logic [63:0] prod_b;

    n_cmp = 0; n_bad = 0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;

    // Reset held together with start: start must not be accepted.
    reset = 1'b1; start32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    tick();
    check("rst_start_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_prod", p32, 64'd0);
    check("rst_prod8", 64'(p8), 64'd0);
    start32 = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_busy", 64'(busy32), 64'd0);

    // 3 x 5 with busy/done timing and hold.
    start_op32(32'd3, 32'd5);
    check("t1_busy_e0", 64'(busy32), 64'd1);
    for (int k = 1; k < 32; k++) begin
      tick();
      check("t1_busy_run", 64'({busy32, done32}), 64'b10);
    end
    tick();
    check("t1_done_e32", 64'({busy32, done32}), 64'b01);
    check("t1_prod", p32, 64'h0000_0000_0000_000F);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_hold", p32, 64'h0000_0000_0000_000F);
      check("t1_hold_done", 64'(done32), 64'd1);
    end

    // All-ones operands exercise the carry into bit 63.
    start_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t2_done_clear", 64'(done32), 64'd0);
    wait_done32("t2", 64'hFFFF_FFFE_0000_0001);

    // Start pulsed during RUN is ignored.
    start_op32(32'd7, 32'd9);
    for (int k = 0; k < 10; k++) tick();
    a32 = 32'd2; b32 = 32'd2; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("t3_still_busy", 64'(busy32), 64'd1);
    begin
      int lat;
      lat = 11;
      while (!done32 && lat < 40) begin
        tick();
        lat++;
      end
      check("t3_lat", 64'(lat), 64'd32);
      check("t3_prod", p32, 64'd63);
    end

    // Asynchronous reset between E15 and E16.
    start_op32(32'd12345, 32'd678);
    for (int k = 0; k < 15; k++) tick();
    #2 reset = 1'b1;
    #1;
    check("t4_rst_prod", p32, 64'd0);
    check("t4_rst_flags", 64'({busy32, done32}), 64'b00);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t4_idle", 64'({busy32, done32}), 64'b00);
    start_op32(32'd4, 32'd6);
    wait_done32("t4_after", 64'd24);

    // Back-to-back with start held high.
    a32 = 32'd0; b32 = 32'd123; start32 = 1'b1;
    tick();
    a32 = 32'd1; b32 = 32'h8000_0000;
    first_done = -1; second_done = -1; done_cnt = 0;
    prod_a = '1; prod_b = '1;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (done32) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k; prod_a = p32;
        end else begin
          second_done = k; prod_b = p32;
        end
      end
    end
    start32 = 1'b0;
    check("t5_first_at", 64'(first_done), 64'd32);
    check("t5_second_at", 64'(second_done), 64'd65);
    check("t5_pulses", 64'(done_cnt), 64'd2);
    check("t5_prod0", prod_a, 64'd0);
    check("t5_prod1", prod_b, 64'h0000_0000_8000_0000);

    // WIDTH=8 instance.
    run8("t6_ff", 8'hFF, 8'hFF, 16'hFE01);
    run8("t6_zero", 8'h00, 8'hAB, 16'h0000);
    run8("t6_mix", 8'h0D, 8'h0B, 16'h008F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential unsigned shift-add multiplier for the hw2 multiplier datapath. A `start` pulse loads the operands. The block then takes one multiplicand-add/shift step per clock into a 2·WIDTH product register, whose low half is seeded with the multiplier. It raises `done` and holds the full-width product until the next accepted start.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range ≥ 2; product is 2·WIDTH bits.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a multiply; accepted only when `busy`=0.
- `multiplicand`  in  WIDTH: operand A; captured on the accepting edge.
- `multiplier`  in  WIDTH: operand B; captured on the accepting edge into `product[WIDTH-1:0]`.
- `busy`  out  1: high while steps are in progress.
- `done`  out  1: high while `product` holds a completed result.
- `product`  out  2·WIDTH: product register; the final value is A·B, unsigned.

## Operation
- States:
  - IDLE: after reset; `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the step counter reaches WIDTH.
  - DONE→RUN on `start`.
  - All other cases hold state.
- Accept edge (state IDLE or DONE, `start`=1):
  - `product` ← {WIDTH'b0, `multiplier`}.
  - Internal `mcand` ← `multiplicand`.
  - Step counter ← 0.
  - `done` ← 0, `busy` ← 1.
- Step edge (RUN), with U = `product[2W-1:W]` and L = `product[W-1:0]`:
  - sum (WIDTH+1 bits) = U + (L[0] ? `mcand` : 0).
  - `product` ← {sum, L} >> 1, i.e. the carry out of the add is shifted into bit 2W-1.
  - Counter increments.
- Arithmetic width rules:
  - The add is carried at WIDTH+1 bits, so no overflow is lost.
  - The step counter is $clog2(WIDTH+1) bits.
- `start` while RUN is ignored: no restart, no queueing.
- `multiplicand` and `multiplier` are don't-care outside the accept edge. Changes during RUN must not affect the result.
- `product` is undefined-but-deterministic during RUN (partial value). It is valid only while `done`=1, and is held unchanged in DONE until the next accept.
- Reset, asynchronous, at any time including mid-RUN:
  - state IDLE, `busy`=0, `done`=0, `product`=0, `mcand`=0, counter 0.
  - No output glitch beyond the reset assertion itself.
- Simultaneous `reset` and `start`: reset wins; `start` is not accepted.
- Zero operands take the full WIDTH steps; there is no early termination.

## Timing
- Latency from the accept edge E0 to `done`=1:
  - Steps occur on edges E1..E_WIDTH.
  - `busy` falls and `done` rises on edge E_WIDTH, i.e. WIDTH cycles after E0.
  - The result is visible WIDTH cycles after the accepting edge.
- `busy` rises on E0; `busy` and `done` are never both high.
- Throughput, back-to-back:
  - `start` held high through DONE is accepted on the first DONE cycle.
  - Each multiply occupies WIDTH+1 edges, including the accept edge.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- WIDTH=32, A=3, B=5, one-cycle `start` → `busy`=1 on E0..E31; `done`=1 and `product`=64'h0000_0000_0000_000F from E32; the value is held 10 further cycles.
- WIDTH=32, A=B=32'hFFFF_FFFF → `product`=64'hFFFF_FFFE_0000_0001 at `done`. Covers the carry-out path into bit 63.
- WIDTH=32, A=7, B=9 started, then `start` pulsed with A=2, B=2 at step 10 while busy → the second start is ignored; `product`=63 at done.
- WIDTH=32, A=12345, B=678, `reset` asserted asynchronously between edges E15 and E16 →
  - outputs are zero immediately;
  - state IDLE;
  - a new start with A=4, B=6 yields 24 after 32 cycles.
- WIDTH=32, `start` held high continuously, operands changing each accept →
  - `done` pulses for one cycle every 33 edges;
  - each product is correct: 0×X=0, 1×32'h8000_0000=64'h0000_0000_8000_0000.
- WIDTH=8 instance, A=8'hFF, B=8'hFF → `product`=16'hFE01 with `done` 8 cycles after E0; A=0, B=8'hAB → 0.
